mem_port_arbiter: RTL and testbench

// - Shares one single-ported unified memory between the instruction-fetch (IF) and data-memory (DM) ports of the RISC-V core.
// - One outstanding memory transaction at a time; DM has priority, with a streak limit so IF cannot starve.
// - Sits between the core's fetch/load-store logic and the memory. The core stalls on missing gnt/rvalid.

---
 rtl/mem_port_arbiter_pkg.sv | 32 +++
 rtl/mem_port_arbiter_if.sv | 51 +++++
 rtl/mem_port_arbiter_timer.sv | 29 ++
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/DM memory port arbiter.
// FSM encodings, transaction owner codes and the fetch byte-enable pattern.
package mem_port_arbiter_pkg;

    localparam int unsigned DataW   = 32;
    localparam int unsigned BeW     = 4;
    localparam logic [BeW-1:0] FetchBe = 4'hF;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWaitIf = 2'd1,
        StWaitDm = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OwnNone = 2'd0,
        OwnIf   = 2'd1,
        OwnDm   = 2'd2
    } owner_e;

    // Owner of the outstanding transaction implied by the FSM state.
    function automatic owner_e state_owner(arb_state_e state);
        owner_e owner;
        unique case (state)
            StWaitIf: owner = OwnIf;
            StWaitDm: owner = OwnDm;
            default:  owner = OwnNone;
        endcase
        return owner;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and memory-side signals around the arbiter.
// The slave modport is the arbiter's view; master is the core-plus-memory environment.
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    logic               if_req;
    logic [DataW-1:0]   if_addr;
    logic               if_gnt;
    logic               if_rvalid;
    logic [DataW-1:0]   if_rdata;

    logic               dm_req;
    logic               dm_we;
    logic [BeW-1:0]     dm_be;
    logic [DataW-1:0]   dm_addr;
    logic [DataW-1:0]   dm_wdata;
    logic               dm_gnt;
    logic               dm_rvalid;
    logic [DataW-1:0]   dm_rdata;

    logic               mem_req;
    logic               mem_we;
    logic [BeW-1:0]     mem_be;
    logic [DataW-1:0]   mem_addr;
    logic [DataW-1:0]   mem_wdata;
    logic               mem_rvalid;
    logic [DataW-1:0]   mem_rdata;

    logic               bus_err;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        output dm_gnt, dm_rvalid, dm_rdata,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rvalid, mem_rdata,
        output bus_err
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rvalid, mem_rdata,
        input  bus_err
    );

endinterface

// File: rtl/mem_port_arbiter_timer.sv
// Watchdog for an outstanding memory access: counts enabled cycles since the last clear
// and flags expiry once TIMEOUT such cycles have elapsed.
module mem_port_arbiter_timer #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] r_count;
    logic            w_at_limit;

    assign w_at_limit = (r_count == CntW'(TIMEOUT));
    assign o_expire   = i_en && w_at_limit;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_count <= '0;
        end else if (i_en && !w_at_limit) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access, one
// transaction in flight, DM priority bounded by a streak limit, and a response watchdog.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned DM_MAX_STREAK = 4,
    parameter int unsigned TIMEOUT       = 64
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    mem_port_arbiter_if.slave        arb_bus
);

    localparam int unsigned StreakW = $clog2(DM_MAX_STREAK + 1);

    arb_state_e         r_state;
    arb_state_e         w_state_next;
    logic [StreakW-1:0] r_streak;
    logic [StreakW-1:0] w_streak_next;
    logic               r_dm_we;

    owner_e             w_owner;
    logic               w_in_wait;
    logic               w_respond;
    logic               w_expire;
    logic               w_timed_out;
    logic               w_slot;
    logic               w_streak_full;
    logic               w_grant_dm;
    logic               w_grant_if;

    logic               w_if_rvalid;
    logic [DataW-1:0]   w_if_rdata;
    logic               w_dm_rvalid;
    logic [DataW-1:0]   w_dm_rdata;
    logic               w_bus_err;
    logic               w_mem_req;
    logic               w_mem_we;
    logic [BeW-1:0]     w_mem_be;
    logic [DataW-1:0]   w_mem_addr;
    logic [DataW-1:0]   w_mem_wdata;

    assign w_owner     = state_owner(r_state);
    assign w_in_wait   = (w_owner != OwnNone);
    assign w_respond   = w_in_wait && arb_bus.mem_rvalid;
    assign w_timed_out = w_expire && !i_reset;

    // A new command may go out while idle or in the very cycle the previous one returns.
    assign w_slot        = !i_reset && ((r_state == StIdle) || w_respond);
    assign w_streak_full = (r_streak == StreakW'(DM_MAX_STREAK));
    assign w_grant_dm    = w_slot && arb_bus.dm_req && !(arb_bus.if_req && w_streak_full);
    assign w_grant_if    = w_slot && arb_bus.if_req && !w_grant_dm;

    mem_port_arbiter_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clr    (w_grant_dm || w_grant_if),
        .i_en     (w_in_wait && !arb_bus.mem_rvalid),
        .o_expire (w_expire)
    );

    always_comb begin
        w_streak_next = r_streak;
        if (w_grant_if) begin
            w_streak_next = '0;
        end else if (w_grant_dm) begin
            if (!arb_bus.if_req) begin
                w_streak_next = '0;
            end else if (!w_streak_full) begin
                w_streak_next = r_streak + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_if_rvalid  = 1'b0;
        w_if_rdata   = '0;
        w_dm_rvalid  = 1'b0;
        w_dm_rdata   = '0;
        w_bus_err    = 1'b0;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_be     = '0;
        w_mem_addr   = '0;
        w_mem_wdata  = '0;

        if (!i_reset) begin
            unique case (r_state)
                StIdle: begin
                    w_state_next = StIdle;
                end
                StWaitIf: begin
                    if (w_respond) begin
                        w_if_rvalid  = 1'b1;
                        w_if_rdata   = arb_bus.mem_rdata;
                        w_state_next = StIdle;
                    end else if (w_timed_out) begin
                        w_if_rvalid  = 1'b1;
                        w_bus_err    = 1'b1;
                        w_state_next = StIdle;
                    end
                end
                StWaitDm: begin
                    if (w_respond) begin
                        w_dm_rvalid  = 1'b1;
                        w_dm_rdata   = r_dm_we ? '0 : arb_bus.mem_rdata;
                        w_state_next = StIdle;
                    end else if (w_timed_out) begin
                        w_dm_rvalid  = 1'b1;
                        w_bus_err    = 1'b1;
                        w_state_next = StIdle;
                    end
                end
                default: begin
                    w_state_next = StIdle;
                end
            endcase

            if (w_grant_dm) begin
                w_mem_req    = 1'b1;
                w_mem_we     = arb_bus.dm_we;
                w_mem_be     = arb_bus.dm_be;
                w_mem_addr   = arb_bus.dm_addr;
                w_mem_wdata  = arb_bus.dm_wdata;
                w_state_next = StWaitDm;
            end else if (w_grant_if) begin
                w_mem_req    = 1'b1;
                w_mem_be     = FetchBe;
                w_mem_addr   = arb_bus.if_addr;
                w_state_next = StWaitIf;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= StIdle;
            r_streak <= '0;
            r_dm_we  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_streak <= w_streak_next;
            if (w_grant_dm) begin
                r_dm_we <= arb_bus.dm_we;
            end
        end
    end

    assign arb_bus.if_gnt    = w_grant_if;
    assign arb_bus.if_rvalid = w_if_rvalid;
    assign arb_bus.if_rdata  = w_if_rdata;
    assign arb_bus.dm_gnt    = w_grant_dm;
    assign arb_bus.dm_rvalid = w_dm_rvalid;
    assign arb_bus.dm_rdata  = w_dm_rdata;
    assign arb_bus.mem_req   = w_mem_req;
    assign arb_bus.mem_we    = w_mem_we;
    assign arb_bus.mem_be    = w_mem_be;
    assign arb_bus.mem_addr  = w_mem_addr;
    assign arb_bus.mem_wdata = w_mem_wdata;
    assign arb_bus.bus_err   = w_bus_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench for mem_port_arbiter: requesters, a latency-programmable
// memory and a reference model of arbitration order, memory contents and timeouts.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int unsigned MaxStreak = 4;
    localparam int unsigned Tmo       = 64;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dm_op_t;

    typedef struct {
        bit          is_dm;
        logic [31:0] data;
        bit          err;
    } resp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        if_req_d     = 1'b0;
    logic [31:0] if_addr_d    = '0;
    logic        dm_req_d     = 1'b0;
    logic        dm_we_d      = 1'b0;
    logic [3:0]  dm_be_d      = '0;
    logic [31:0] dm_addr_d    = '0;
    logic [31:0] dm_wdata_d   = '0;
    logic        mem_rvalid_d = 1'b0;
    logic [31:0] mem_rdata_d  = '0;

    mem_port_arbiter_if bus ();

    assign bus.if_req     = if_req_d;
    assign bus.if_addr    = if_addr_d;
    assign bus.dm_req     = dm_req_d;
    assign bus.dm_we      = dm_we_d;
    assign bus.dm_be      = dm_be_d;
    assign bus.dm_addr    = dm_addr_d;
    assign bus.dm_wdata   = dm_wdata_d;
    assign bus.mem_rvalid = mem_rvalid_d;
    assign bus.mem_rdata  = mem_rdata_d;

    mem_port_arbiter #(
        .DM_MAX_STREAK (MaxStreak),
        .TIMEOUT       (Tmo)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .arb_bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Stimulus queues and knobs owned by the sequence; consumed by the environment process.
    logic [31:0] if_q[$];
    dm_op_t      dm_q[$];
    int          lat       = 1;
    int          if_gap    = 0;
    int          dm_gap    = 0;
    bit          rand_gap  = 1'b0;
    int          dead_arm  = 0;
    int          stale_arm = 0;

    // Environment and model state.
    resp_t       exp_q[$];
    bit          gnt_log[$];
    logic [31:0] ref_mem  [int unsigned];
    logic [31:0] phys_mem [int unsigned];
    bit          tb_out     = 1'b0;
    int          wait_cnt   = 0;
    int          streak_m   = 0;
    bit          if_granted = 1'b0;
    bit          dm_granted = 1'b0;
    int          if_hold    = 0;
    int          dm_hold    = 0;
    int          dead_taken = 0;
    int          stale_done = 0;
    bit          pend       = 1'b0;
    bit          pend_dead  = 1'b0;
    int          pend_cnt   = 0;
    logic        pend_we;
    logic [3:0]  pend_be;
    logic [31:0] pend_addr;
    logic [31:0] pend_wdata;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] phys_rd(input logic [31:0] a);
        return phys_mem.exists(a) ? phys_mem[a] : init_word(a);
    endfunction

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always begin : env
        bit    prev_out, resp_rv, resp_to, slot, exp_dm, exp_if, dead;
        resp_t e;
        dm_op_t op;

        @(posedge clk);
        #1;
        // Requesters: hold until granted, then optionally idle before the next request.
        if (if_granted) begin
            if_granted = 1'b0;
            if_req_d   = 1'b0;
            if_hold    = rand_gap ? int'($urandom_range(0, 2)) : if_gap;
        end
        if (!if_req_d) begin
            if (if_hold > 0) if_hold--;
            else if (if_q.size() > 0) begin
                if_addr_d = if_q.pop_front();
                if_req_d  = 1'b1;
            end
        end
        if (dm_granted) begin
            dm_granted = 1'b0;
            dm_req_d   = 1'b0;
            dm_hold    = rand_gap ? int'($urandom_range(0, 2)) : dm_gap;
        end
        if (!dm_req_d) begin
            if (dm_hold > 0) dm_hold--;
            else if (dm_q.size() > 0) begin
                op         = dm_q.pop_front();
                dm_we_d    = op.we;
                dm_be_d    = op.be;
                dm_addr_d  = op.addr;
                dm_wdata_d = op.wdata;
                dm_req_d   = 1'b1;
            end
        end

        #1;
        // Memory: answers each accepted command after lat cycles unless told to stay silent.
        mem_rvalid_d = 1'b0;
        mem_rdata_d  = '0;
        if (stale_arm != stale_done) begin
            stale_done++;
            mem_rvalid_d = 1'b1;
            mem_rdata_d  = 32'hBAD0_BAD0;
        end else if (pend && !pend_dead) begin
            pend_cnt--;
            if (pend_cnt <= 0) begin
                pend         = 1'b0;
                mem_rvalid_d = 1'b1;
                if (pend_we) begin
                    phys_mem[pend_addr] = merge(phys_rd(pend_addr), pend_wdata, pend_be);
                    mem_rdata_d = $urandom;
                end else begin
                    mem_rdata_d = phys_rd(pend_addr);
                end
            end
        end

        @(negedge clk);
        if (reset) begin
            chk("reset_outputs", {bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.dm_gnt,
                bus.dm_rvalid, bus.dm_rdata, bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr,
                bus.mem_wdata, bus.bus_err}, '0);
            tb_out = 1'b0; wait_cnt = 0; streak_m = 0; pend = 1'b0;
            if_granted = 1'b0; dm_granted = 1'b0;
            exp_q.delete();
        end else begin
            prev_out = tb_out;
            resp_rv  = tb_out && mem_rvalid_d;
            resp_to  = tb_out && !mem_rvalid_d && (wait_cnt == Tmo);
            if (resp_rv || resp_to) begin
                if (exp_q.size() == 0) begin
                    chk("resp_expected", 1'b0, 1'b1);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_if_rvalid", bus.if_rvalid, !e.is_dm);
                    chk("resp_dm_rvalid", bus.dm_rvalid, e.is_dm);
                    chk("resp_rdata", e.is_dm ? bus.dm_rdata : bus.if_rdata, e.data);
                    chk("resp_bus_err", bus.bus_err, e.err);
                end
                tb_out = 1'b0;
                pend   = 1'b0;
            end else begin
                chk("no_response", {bus.if_rvalid, bus.dm_rvalid, bus.bus_err}, 3'b000);
            end
            if (tb_out) wait_cnt++;

            slot   = !prev_out || resp_rv;
            exp_dm = slot && dm_req_d && !(if_req_d && streak_m >= int'(MaxStreak));
            exp_if = slot && if_req_d && !exp_dm;
            chk("grant", {bus.if_gnt, bus.dm_gnt, bus.mem_req}, {exp_if, exp_dm, exp_if || exp_dm});

            dead = 1'b0;
            if ((exp_if || exp_dm) && dead_arm != dead_taken) begin
                dead_taken++;
                dead = 1'b1;
            end
            if (exp_dm) begin
                chk("dm_cmd", {bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata},
                    {dm_we_d, dm_be_d, dm_addr_d, dm_wdata_d});
                e.is_dm = 1'b1;
                e.err   = dead;
                e.data  = (dead || dm_we_d) ? 32'h0 : ref_rd(dm_addr_d);
                if (dm_we_d && !dead) ref_mem[dm_addr_d] = merge(ref_rd(dm_addr_d), dm_wdata_d, dm_be_d);
                streak_m = if_req_d ? ((streak_m < int'(MaxStreak)) ? streak_m + 1 : streak_m) : 0;
                dm_granted = 1'b1;
                gnt_log.push_back(1'b1);
            end else if (exp_if) begin
                chk("if_cmd", {bus.mem_we, bus.mem_be, bus.mem_addr}, {1'b0, 4'hF, if_addr_d});
                e.is_dm = 1'b0;
                e.err   = dead;
                e.data  = dead ? 32'h0 : ref_rd(if_addr_d);
                streak_m   = 0;
                if_granted = 1'b1;
                gnt_log.push_back(1'b0);
            end else begin
                chk("idle_cmd", {bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata}, '0);
            end
            if (exp_if || exp_dm) begin
                exp_q.push_back(e);
                tb_out   = 1'b1;
                wait_cnt = 0;
            end
            if (bus.mem_req) begin
                pend       = 1'b1;
                pend_dead  = dead;
                pend_cnt   = lat;
                pend_we    = bus.mem_we;
                pend_be    = bus.mem_be;
                pend_addr  = bus.mem_addr;
                pend_wdata = bus.mem_wdata;
            end
        end
    end

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((if_q.size() != 0 || dm_q.size() != 0 || if_req_d || dm_req_d || tb_out ||
                exp_q.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s: still busy after %0d cycles, required idle", name, budget);
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        bit     exp_order[6];
        dm_op_t op;

        exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);

        // Fetch only, one-cycle memory, requester idles a cycle after each grant.
        lat = 1; if_gap = 1;
        if_q.push_back(32'h0); if_q.push_back(32'h4); if_q.push_back(32'h8);
        wait_idle(100, "if_only");

        // Both ports saturated: DM wins up to the streak limit, then IF gets one slot.
        if_gap = 0; dm_gap = 0;
        gnt_log.delete();
        for (int i = 0; i < 10; i++) begin
            if_q.push_back(32'h200 + 32'(i * 4));
            op = '{we: 1'b0, be: 4'hF, addr: 32'h400 + 32'(i * 4), wdata: 32'h0};
            dm_q.push_back(op);
        end
        wait_idle(300, "both_held");
        if (gnt_log.size() < 6) chk("order_len", 1'b0, 1'b1);
        else for (int i = 0; i < 6; i++) chk("grant_order", gnt_log[i], exp_order[i]);

        // Partial store followed by a load of the same word.
        op = '{we: 1'b1, be: 4'b0011, addr: 32'h100, wdata: 32'hDEAD_BEEF};
        dm_q.push_back(op);
        op = '{we: 1'b0, be: 4'hF, addr: 32'h100, wdata: 32'h0};
        dm_q.push_back(op);
        wait_idle(100, "store_load");

        // Random mix over a shared small address range at several latencies.
        rand_gap = 1'b1;
        for (int blk = 0; blk < 3; blk++) begin
            lat = (blk == 2) ? 4 : blk + 1;
            for (int i = 0; i < 60; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    if_q.push_back(32'($urandom_range(0, 63)) << 2);
                end else begin
                    op.we    = 1'($urandom_range(0, 1));
                    op.be    = op.we ? 4'($urandom_range(1, 15)) : 4'hF;
                    op.addr  = 32'($urandom_range(0, 63)) << 2;
                    op.wdata = $urandom;
                    dm_q.push_back(op);
                end
            end
            wait_idle(3000, "random_mix");
        end
        rand_gap = 1'b0;

        // Back-to-back DM at latency 3: each response cycle must carry the next grant.
        lat = 3;
        for (int i = 0; i < 6; i++) begin
            op = '{we: 1'b0, be: 4'hF, addr: 32'h80 + 32'(i * 4), wdata: 32'h0};
            dm_q.push_back(op);
        end
        wait_idle(200, "back_to_back");

        // Silent memory for the DM load; the waiting fetch is granted only after the abort.
        lat = 1;
        dead_arm++;
        op = '{we: 1'b0, be: 4'hF, addr: 32'h40, wdata: 32'h0};
        dm_q.push_back(op);
        if_q.push_back(32'h44);
        wait_idle(300, "timeout");

        // Reset while a DM load is outstanding, then a stale response right after reset.
        lat = 10;
        op = '{we: 1'b0, be: 4'hF, addr: 32'h48, wdata: 32'h0};
        dm_q.push_back(op);
        for (int n = 0; n < 20 && !tb_out; n++) @(posedge clk);
        chk("dm_outstanding_before_reset", tb_out, 1'b1);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        stale_arm++;
        repeat (4) @(posedge clk);
        lat = 2;
        if_q.push_back(32'h4C);
        wait_idle(100, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
